// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx_byte receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit and the PARITY state).
package uart_rx_pkg;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_rx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_byte_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Reset value is a parameter so an idle-high line does not look like a start bit.
module rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; oldest stage is the output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// Serial 8N1 (or 8E1 with UART_RX_PARITY_EN) byte receiver.
// Produces a parallel byte plus a one-cycle strobe; frame/parity errors pulse
// their own flags and never update the byte. Optional macro: UART_RX_PARITY_EN.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_rx_state_t    state_q,      state_d;
    logic [CNT_W-1:0]  cyc_cnt_q,    cyc_cnt_d;
    logic [2:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic              valid_q,      valid_d;
    logic              frame_err_q,  frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              stop_par_bad;

    rx_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    assign stop_par_bad = par_bad_q;
`else
    assign stop_par_bad = 1'b0;
`endif

    // Next-state logic: mid-bit sampling FSM with cycle and bit counters.
    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    cyc_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (cyc_cnt_q == HALF_M1) begin
                    cyc_cnt_d = '0;
                    // A high line at mid-start means a glitch, not a frame.
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cyc_cnt_q == FULL_M1) begin
                    cyc_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cyc_cnt_q == FULL_M1) begin
                    cyc_cnt_d = '0;
                    // Even parity: data bits plus parity bit must hold an even count of ones.
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = ST_STOP;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cyc_cnt_q == FULL_M1) begin
                    cyc_cnt_d = '0;
                    if (rx_s) begin
                        if (stop_par_bad) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        // Re-enter IDLE half a bit early so a following start bit is caught.
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                // A break holds the line low; wait it out instead of decoding zeros.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cyc_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_cnt_q    <= cyc_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte (CLKS_PER_BIT=16).
// Reference model: each frame's expected strobe cycle is computed from its
// drive cycle with plain arithmetic; expected bytes come from the stimulus.
`timescale 1ns/1ps
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int BITS_BEFORE_STOP = 10;
`else
    localparam int BITS_BEFORE_STOP = 9;
`endif
    localparam int FRAME_BITS = BITS_BEFORE_STOP + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [7:0] d; } ev_t;
    ev_t        vq[$];
    int         fq[$];
    int         pq[$];
    int         multi_hot = 0;
    logic [7:0] sh [4];

    int errors = 0;
    int checks = 0;

    // Event logger and downstream 4-stage shifter model, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vq.push_back('{cyc, data});
            sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = data;
        end
        if (frame_err === 1'b1) fq.push_back(cyc);
        if (parity_err === 1'b1) pq.push_back(cyc);
        if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) multi_hot++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame driven starting at cycle n: t0 = n+3, stop sampled at t0 + HALF + BITS_BEFORE_STOP*CPB.
    function automatic int exp_cyc(input int n);
        return n + 3 + HALF + BITS_BEFORE_STOP * CPB;
    endfunction

    function automatic logic [11:0] make_frame(input logic [7:0] d, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
        return {1'b0, stop_bit, ^d, d, 1'b0};
`else
        return {2'b00, stop_bit, d, 1'b0};
`endif
    endfunction

    task automatic send_bits(input logic [11:0] bits, input int last_len, output int n);
        n = cyc;
        for (int i = 0; i < FRAME_BITS; i++) begin
            rx = bits[i];
            repeat ((i == FRAME_BITS - 1) ? last_len : CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int k);
        rx = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_valid(input string tag, input int n, input logic [7:0] d);
        ev_t e;
        check({tag, "_present"}, 32'(vq.size() > 0), 32'd1);
        if (vq.size() > 0) begin
            e = vq.pop_front();
            check({tag, "_cyc"}, e.c, exp_cyc(n));
            check({tag, "_data"}, {24'd0, e.d}, {24'd0, d});
        end
    endtask

    int         n, nq[$];
    logic [7:0] bq[$];
    logic [7:0] last_byte, b;
    logic [11:0] f;

    initial begin
        for (int i = 0; i < 4; i++) sh[i] = 8'h00;
        rx    = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        idle(4);
        check("idle_busy", busy, 1'b0);

        // Single 0xA5 frame
        send_bits(make_frame(8'hA5, 1'b1), CPB, n);
        idle(10);
        expect_valid("a5", n, 8'hA5);
        check("a5_no_ferr", fq.size(), 0);
        check("a5_no_perr", pq.size(), 0);
        last_byte = 8'hA5;

        // Back-to-back 0x11..0x44 into the downstream shifter
        for (int i = 1; i <= 4; i++) begin
            send_bits(make_frame(8'(i * 8'h11), 1'b1), CPB, n);
            nq.push_back(n);
        end
        idle(10);
        for (int i = 1; i <= 4; i++) expect_valid("b2b", nq.pop_front(), 8'(i * 8'h11));
        check("b2b_count", vq.size(), 0);
        check("shifter_out", {24'd0, sh[3]}, 32'h11);
        last_byte = 8'h44;

        // Random bytes with random idle gaps
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            send_bits(make_frame(b, 1'b1), CPB, n);
            nq.push_back(n);
            bq.push_back(b);
            last_byte = b;
            idle($urandom_range(0, 5));
        end
        idle(10);
        while (bq.size() > 0) expect_valid("rand", nq.pop_front(), bq.pop_front());
        check("rand_data_hold", {24'd0, data}, {24'd0, last_byte});

        // Start-bit glitch: 3 cycles low
        n = cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        wait_until(n + 3 + 4);
        check("glitch_busy_hi", busy, 1'b1);
        wait_until(n + 3 + 9);
        check("glitch_busy_lo", busy, 1'b0);
        idle(20);
        check("glitch_no_valid", vq.size(), 0);
        check("glitch_no_ferr", fq.size(), 0);
        check("glitch_no_perr", pq.size(), 0);

        // Frame error: 0x3C with low stop bit held 40 extra cycles
        send_bits(make_frame(8'h3C, 1'b0), CPB + 40, n);
        check("ferr_busy_held", busy, 1'b1);
        wait_until(n + 10);
        wait_until(n + BITS_BEFORE_STOP * CPB + CPB + 40 + 10);
        check("ferr_busy_lo", busy, 1'b0);
        check("ferr_count", fq.size(), 1);
        if (fq.size() > 0) check("ferr_cyc", fq.pop_front(), exp_cyc(n));
        check("ferr_no_valid", vq.size(), 0);
        check("ferr_data_kept", {24'd0, data}, {24'd0, last_byte});
        send_bits(make_frame(8'hC3, 1'b1), CPB, n);
        idle(10);
        expect_valid("after_ferr", n, 8'hC3);

        // Reset asserted after data bit 4 of 0xFF
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mrst_data", {24'd0, data}, 32'h0);
        check("mrst_valid", valid, 1'b0);
        check("mrst_ferr", frame_err, 1'b0);
        check("mrst_perr", parity_err, 1'b0);
        check("mrst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(5);
        check("mrst_busy_after", busy, 1'b0);
        send_bits(make_frame(8'h5A, 1'b1), CPB, n);
        idle(10);
        expect_valid("after_rst", n, 8'h5A);
        last_byte = 8'h5A;

`ifdef UART_RX_PARITY_EN
        // 0x07 with wrong parity (0), then with correct parity (1)
        f = {1'b0, 1'b1, 1'b0, 8'h07, 1'b0};
        send_bits(f, CPB, n);
        idle(10);
        check("par_count", pq.size(), 1);
        if (pq.size() > 0) check("par_cyc", pq.pop_front(), exp_cyc(n));
        check("par_no_valid", vq.size(), 0);
        check("par_data_kept", {24'd0, data}, {24'd0, last_byte});
        send_bits(make_frame(8'h07, 1'b1), CPB, n);
        idle(10);
        expect_valid("par_ok", n, 8'h07);
`endif

        check("one_hot_pulses", multi_hot, 0);
        check("final_valid_q", vq.size(), 0);
        check("final_ferr_q", fq.size(), 0);
        check("final_perr_q", pq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
